// File: rtl/rsp_s2_mask_combine_gen2_pkg.sv
// Shared types and helpers for the stage-2 LF/HF mask combiner.
package rsp_comb_pkg;

  typedef enum logic {
    MODE_COMPLEX = 1'b0,
    MODE_REAL    = 1'b1
  } mode_e;

  // Widest lane count the lane-mask helper can address.
  localparam int unsigned MAX_LANES = 64;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Keep bit for data lane k: one mask bit per lane in real mode,
  // one mask bit per lane pair in complex mode.
  function automatic logic lane_keep(input logic [MAX_LANES-1:0] m,
                                     input mode_e mode,
                                     input int unsigned k);
    return (mode == MODE_REAL) ? m[k] : m[k >> 1];
  endfunction

endpackage

// File: rtl/rsp_s2_mask_combine_gen2_if.sv
// Data-beat handshake bus: input beat stream and masked output stream.
interface rsp_s2_mask_combine_gen2_if #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [NUM_LANES*DATA_WIDTH-1:0] i_x;
  logic                            i_x_valid;
  logic                            o_x_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] o_y;
  logic                            o_y_valid;
  logic                            o_y_last;
  logic                            i_y_ready;

  modport slave  (input  i_x, i_x_valid, i_y_ready,
                  output o_x_ready, o_y, o_y_valid, o_y_last);
  modport master (output i_x, i_x_valid, i_y_ready,
                  input  o_x_ready, o_y, o_y_valid, o_y_last);
endinterface

// File: rtl/rsp_s2_mask_combine_gen2_fifo.sv
// Synchronous mask FIFO with registered level; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
module rsp_mask_fifo
  import rsp_comb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [level_w(DEPTH)-1:0]  o_level,
  output logic                       o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_push;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/rsp_s2_mask_combine_gen2.sv
// Stage-2 LF/HF mask combiner: pairs each data beat with the oldest LF and HF
// masks, zeroes rejected lanes, frames the output and flags mask overflow.
module rsp_s2_mask_combine_gen2
  import rsp_comb_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 8,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned MASK_FIFO_DEPTH = 16,
  parameter int unsigned FRAME_LEN_W     = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_mode,
  input  logic [FRAME_LEN_W-1:0]             i_frame_len,
  input  logic [NUM_LANES-1:0]               i_lf_mask,
  input  logic                               i_lf_mask_valid,
  input  logic [NUM_LANES-1:0]               i_hf_mask,
  input  logic                               i_hf_mask_valid,
  rsp_s2_mask_combine_gen2_if.slave          bus,
  output logic                               o_ovf_err,
  output logic [$clog2(MASK_FIFO_DEPTH):0]   o_lf_level,
  output logic [$clog2(MASK_FIFO_DEPTH):0]   o_hf_level
);
  logic [NUM_LANES-1:0]            w_lf_head;
  logic [NUM_LANES-1:0]            w_hf_head;
  logic                            w_lf_empty, w_hf_empty;
  logic                            w_lf_full, w_hf_full;
  logic                            w_lf_drop, w_hf_drop;
  logic                            w_x_ready;
  logic                            w_fire;
  logic                            w_first;
  mode_e                           w_mode;
  logic [FRAME_LEN_W-1:0]          w_len;
  logic                            w_last;
  logic [NUM_LANES-1:0]            w_m;
  logic [NUM_LANES*DATA_WIDTH-1:0] w_y;

  logic [FRAME_LEN_W-1:0]          r_cnt;
  mode_e                           r_mode;
  logic [FRAME_LEN_W-1:0]          r_len;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_y;
  logic                            r_y_valid;
  logic                            r_y_last;
  logic                            r_ovf;

  rsp_mask_fifo #(.WIDTH(NUM_LANES), .DEPTH(MASK_FIFO_DEPTH)) u_lf_fifo (
    .clk(clk), .rst(rst),
    .i_push(i_lf_mask_valid), .i_data(i_lf_mask), .i_pop(w_fire),
    .o_data(w_lf_head), .o_full(w_lf_full), .o_empty(w_lf_empty),
    .o_level(o_lf_level), .o_drop(w_lf_drop)
  );

  rsp_mask_fifo #(.WIDTH(NUM_LANES), .DEPTH(MASK_FIFO_DEPTH)) u_hf_fifo (
    .clk(clk), .rst(rst),
    .i_push(i_hf_mask_valid), .i_data(i_hf_mask), .i_pop(w_fire),
    .o_data(w_hf_head), .o_full(w_hf_full), .o_empty(w_hf_empty),
    .o_level(o_hf_level), .o_drop(w_hf_drop)
  );

  assign w_x_ready     = !w_lf_empty && !w_hf_empty && (!r_y_valid || bus.i_y_ready);
  assign w_fire        = bus.i_x_valid && w_x_ready;
  assign bus.o_x_ready = w_x_ready;
  assign bus.o_y       = r_y;
  assign bus.o_y_valid = r_y_valid;
  assign bus.o_y_last  = r_y_last;
  assign o_ovf_err     = r_ovf;

  // The first beat of a frame uses the live mode/length; later beats use the latched copy.
  assign w_first = (r_cnt == '0);
  assign w_mode  = w_first ? mode_e'(i_mode) : r_mode;
  assign w_len   = w_first ? i_frame_len : r_len;
  assign w_last  = (r_cnt == w_len);
  assign w_m     = w_lf_head & w_hf_head;

  // Zero every data lane whose combined mask bit rejects it.
  always_comb begin
    w_y = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_keep(MAX_LANES'(w_m), w_mode, k))
        w_y[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_x[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output register: load on fire, hold under backpressure, drop valid when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_last  <= 1'b0;
    end else if (w_fire) begin
      r_y       <= w_y;
      r_y_valid <= 1'b1;
      r_y_last  <= w_last;
    end else if (bus.i_y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  // Beat counter with mode/length latched at the start of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mode <= MODE_REAL;
      r_len  <= '0;
    end else if (w_fire) begin
      if (w_first) begin
        r_mode <= w_mode;
        r_len  <= w_len;
      end
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Sticky overflow: a mask was dropped by either FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_lf_drop || w_hf_drop) r_ovf <= 1'b1;
  end
endmodule

// File: tb/tb_rsp_s2_mask_combine_gen2.sv
// Self-checking bench for rsp_s2_mask_combine_gen2 against a queue-based
// transaction model of the mask FIFOs, output register and framing rules.
module tb_rsp_s2_mask_combine_gen2;
  localparam int NL = 8;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int FLW = 12;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic [FLW-1:0] flen;
  logic [NL-1:0] lf, hf;
  logic lfv, hfv;
  logic ovf;
  logic [4:0] lfl, hfl;

  always #5 clk = ~clk;

  rsp_s2_mask_combine_gen2_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) bus ();

  rsp_s2_mask_combine_gen2 #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .MASK_FIFO_DEPTH(DEPTH), .FRAME_LEN_W(FLW)
  ) dut (
    .clk(clk), .rst(rst), .i_mode(mode), .i_frame_len(flen),
    .i_lf_mask(lf), .i_lf_mask_valid(lfv), .i_hf_mask(hf), .i_hf_mask_valid(hfv),
    .bus(bus), .o_ovf_err(ovf), .o_lf_level(lfl), .o_hf_level(hfl)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [NL-1:0] m_lfq[$];
  logic [NL-1:0] m_hfq[$];
  bit m_vld, m_last, m_ovf, m_mode;
  logic [NL*DW-1:0] m_y;
  int m_cnt, m_len;

  function automatic logic [NL*DW-1:0] ramp(input logic [15:0] base);
    logic [NL*DW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*DW +: DW] = base + 16'(k);
    return r;
  endfunction

  function automatic bit m_rdy();
    return m_lfq.size() != 0 && m_hfq.size() != 0 && (!m_vld || bus.i_y_ready);
  endfunction

  task automatic model_reset();
    m_lfq.delete(); m_hfq.delete();
    m_vld = 0; m_last = 0; m_ovf = 0; m_mode = 1; m_y = '0; m_cnt = 0; m_len = 0;
  endtask

  task automatic drive_idle();
    lfv = 0; hfv = 0; lf = '0; hf = '0;
    bus.i_x_valid = 0; bus.i_x = '0; bus.i_y_ready = 1;
  endtask

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic tick();
    bit fire, lf_ok, hf_ok, md, keep;
    int ln;
    logic [NL-1:0] m;
    fire  = bus.i_x_valid && m_rdy();
    lf_ok = lfv && (m_lfq.size() < DEPTH || fire);
    hf_ok = hfv && (m_hfq.size() < DEPTH || fire);
    if ((lfv && !lf_ok) || (hfv && !hf_ok)) m_ovf = 1;
    if (fire) begin
      m  = m_lfq[0] & m_hfq[0];
      md = (m_cnt == 0) ? mode : m_mode;
      ln = (m_cnt == 0) ? int'(flen) : m_len;
      if (m_cnt == 0) begin m_mode = md; m_len = ln; end
      for (int k = 0; k < NL; k++) begin
        keep = md ? m[k] : m[k/2];
        m_y[k*DW +: DW] = keep ? bus.i_x[k*DW +: DW] : 16'h0;
      end
      m_last = (m_cnt == ln);
      m_cnt  = m_last ? 0 : m_cnt + 1;
      m_vld  = 1;
      void'(m_lfq.pop_front()); void'(m_hfq.pop_front());
    end else if (bus.i_y_ready) begin
      m_vld = 0;
    end
    if (lf_ok) m_lfq.push_back(lf);
    if (hf_ok) m_hfq.push_back(hf);
    @(posedge clk); #2;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1;
    model_reset();
    @(posedge clk); #2;
    rst = 0;
  endtask

  task automatic test_reset();
    drive_idle(); mode = 1; flen = '0;
    rst = 1; #1;
    checks++; if (bus.o_y !== '0) begin failures++; $display("FAIL reset_y got=%h exp=0", bus.o_y); end
    checks++; if (bus.o_y_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_y_valid); end
    checks++; if (bus.o_y_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.o_y_last); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (lfl !== 5'd0 || hfl !== 5'd0) begin failures++; $display("FAIL reset_levels got=%0d/%0d exp=0/0", lfl, hfl); end
    checks++; if (bus.o_x_ready !== 1'b0) begin failures++; $display("FAIL reset_xready got=%b exp=0", bus.o_x_ready); end
    apply_reset();
  endtask

  task automatic test_real_mask();
    logic [NL*DW-1:0] exp_y;
    apply_reset(); mode = 1; flen = 12'd3;
    lf = 8'hF0; hf = 8'h3C; lfv = 1; hfv = 1; tick();
    lfv = 0; hfv = 0;
    bus.i_x = ramp(16'h1000); bus.i_x_valid = 1; #1;
    checks++; if (bus.o_x_ready !== m_rdy()) begin failures++; $display("FAIL real_xready got=%b exp=%b", bus.o_x_ready, m_rdy()); end
    tick(); bus.i_x_valid = 0; #1;
    exp_y = '0; exp_y[4*DW +: DW] = 16'h1004; exp_y[5*DW +: DW] = 16'h1005;
    checks++; if (bus.o_y_valid !== 1'b1) begin failures++; $display("FAIL real_valid got=%b exp=1", bus.o_y_valid); end
    checks++; if (bus.o_y !== exp_y || bus.o_y !== m_y) begin failures++; $display("FAIL real_y got=%h exp=%h", bus.o_y, exp_y); end
    checks++; if (bus.o_y_last !== 1'b0) begin failures++; $display("FAIL real_last got=%b exp=0", bus.o_y_last); end
    tick();
  endtask

  task automatic test_complex_mask();
    logic [NL*DW-1:0] exp_y;
    apply_reset(); mode = 0; flen = 12'd0;
    lf = 8'h0B; hf = 8'h09; lfv = 1; hfv = 1; tick();
    lfv = 0; hfv = 0;
    bus.i_x = ramp(16'h1000); bus.i_x_valid = 1; tick();
    bus.i_x_valid = 0; #1;
    exp_y = '0;
    exp_y[0*DW +: DW] = 16'h1000; exp_y[1*DW +: DW] = 16'h1001;
    exp_y[6*DW +: DW] = 16'h1006; exp_y[7*DW +: DW] = 16'h1007;
    checks++; if (bus.o_y !== exp_y || bus.o_y !== m_y) begin failures++; $display("FAIL cplx_y got=%h exp=%h", bus.o_y, exp_y); end
    checks++; if (bus.o_y_last !== 1'b1) begin failures++; $display("FAIL cplx_last_len0 got=%b exp=1", bus.o_y_last); end
    tick();
  endtask

  task automatic test_lf_only();
    apply_reset(); mode = 1; flen = '0;
    lf = 8'hFF; lfv = 1; tick(); lfv = 0;
    bus.i_x = ramp(16'h2000); bus.i_x_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.o_x_ready !== 1'b0 || bus.o_y_valid !== 1'b0) begin failures++; $display("FAIL lfonly_stall got=%b/%b exp=0/0", bus.o_x_ready, bus.o_y_valid); end
      tick();
    end
    hf = 8'h81; hfv = 1; #1;
    checks++; if (bus.o_x_ready !== 1'b0) begin failures++; $display("FAIL lfonly_nobypass got=%b exp=0", bus.o_x_ready); end
    tick(); hfv = 0; #1;
    checks++; if (bus.o_x_ready !== 1'b1) begin failures++; $display("FAIL lfonly_ready got=%b exp=1", bus.o_x_ready); end
    tick(); bus.i_x_valid = 0; #1;
    checks++; if (bus.o_y_valid !== 1'b1 || bus.o_y !== m_y) begin failures++; $display("FAIL lfonly_out got=%b/%h exp=1/%h", bus.o_y_valid, bus.o_y, m_y); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NL*DW-1:0] beat_a, beat_b;
    apply_reset(); mode = 1; flen = 12'd7;
    lf = 8'hA5; hf = 8'hFF; lfv = 1; hfv = 1; tick();
    lf = 8'h5A; tick();
    lfv = 0; hfv = 0;
    bus.i_y_ready = 0; bus.i_x = ramp(16'h3000); bus.i_x_valid = 1; tick();
    beat_a = m_y;
    bus.i_x = ramp(16'h4000);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.o_x_ready !== 1'b0) begin failures++; $display("FAIL bp_xready got=%b exp=0", bus.o_x_ready); end
      checks++; if (bus.o_y_valid !== 1'b1 || bus.o_y !== beat_a) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", bus.o_y_valid, bus.o_y, beat_a); end
      tick();
    end
    bus.i_y_ready = 1; #1;
    checks++; if (bus.o_x_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.o_x_ready); end
    checks++; if (bus.o_y !== beat_a) begin failures++; $display("FAIL bp_first_xfer got=%h exp=%h", bus.o_y, beat_a); end
    tick(); bus.i_x_valid = 0; beat_b = m_y; #1;
    checks++; if (bus.o_y_valid !== 1'b1 || bus.o_y !== beat_b) begin failures++; $display("FAIL bp_second_xfer got=%b/%h exp=1/%h", bus.o_y_valid, bus.o_y, beat_b); end
    tick(); #1;
    checks++; if (bus.o_y_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.o_y_valid); end
  endtask

  task automatic test_overflow();
    apply_reset(); mode = 1; flen = '0;
    lfv = 1;
    for (int i = 0; i < 17; i++) begin lf = 8'($urandom); tick(); end
    lfv = 0; #1;
    checks++; if (lfl !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", lfl); end
    checks++; if (ovf !== 1'b1 || m_ovf != 1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    hf = 8'hFF; hfv = 1; tick(); hfv = 0;
    lf = 8'h77; lfv = 1; bus.i_x = ramp(16'h5000); bus.i_x_valid = 1; #1;
    checks++; if (bus.o_x_ready !== 1'b1) begin failures++; $display("FAIL ovf_fire_ready got=%b exp=1", bus.o_x_ready); end
    tick(); lfv = 0; bus.i_x_valid = 0; #1;
    checks++; if (lfl !== 5'd16 || hfl !== 5'd0) begin failures++; $display("FAIL ovf_pushpop_full got=%0d/%0d exp=16/0", lfl, hfl); end
    checks++; if (bus.o_y !== m_y) begin failures++; $display("FAIL ovf_out got=%h exp=%h", bus.o_y, m_y); end
    tick();
  endtask

  task automatic test_frame_mode();
    apply_reset(); mode = 1; flen = 12'd2;
    lf = 8'hFF; hf = 8'h0F; lfv = 1; hfv = 1;
    for (int i = 0; i < 7; i++) tick();
    lfv = 0; hfv = 0;
    bus.i_x_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.i_x = ramp(16'(16'h6000 + 16'(i * 16)));
      if (i == 1) mode = 0;
      tick(); #1;
      checks++; if (bus.o_y_last !== ((i % 3) == 2)) begin failures++; $display("FAIL frame_last beat=%0d got=%b", i, bus.o_y_last); end
      checks++; if ((i < 3) ? (bus.o_y[NL*DW-1:4*DW] !== '0) : (bus.o_y[NL*DW-1:4*DW] === '0)) begin failures++; $display("FAIL frame_mode beat=%0d got=%h", i, bus.o_y); end
      checks++; if (bus.o_y !== m_y) begin failures++; $display("FAIL frame_y beat=%0d got=%h exp=%h", i, bus.o_y, m_y); end
    end
    // one more beat starts a new frame, then reset lands mid-frame
    tick(); bus.i_x_valid = 0; lfv = 1; tick(); lfv = 0;
    #3; rst = 1; #1;
    checks++; if (bus.o_y !== '0 || bus.o_y_valid !== 1'b0 || bus.o_y_last !== 1'b0) begin failures++; $display("FAIL midrst_out got=%b/%b/%h", bus.o_y_valid, bus.o_y_last, bus.o_y); end
    checks++; if (lfl !== 5'd0 || hfl !== 5'd0 || ovf !== 1'b0) begin failures++; $display("FAIL midrst_state got=%0d/%0d/%b exp=0/0/0", lfl, hfl, ovf); end
    model_reset(); drive_idle();
    @(posedge clk); #2; rst = 0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      lfv = ($urandom_range(3, 0) != 0); lf = 8'($urandom);
      hfv = ($urandom_range(3, 0) != 0); hf = 8'($urandom);
      bus.i_x_valid = ($urandom_range(3, 0) != 0);
      bus.i_x = {$urandom, $urandom, $urandom, $urandom};
      bus.i_y_ready = ($urandom_range(3, 0) != 0);
      mode = 1'($urandom_range(1, 0));
      flen = 12'($urandom_range(3, 0));
      #1;
      checks++; if (bus.o_y_valid !== m_vld) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus.o_y_valid, m_vld); end
      if (m_vld) begin
        checks++; if (bus.o_y !== m_y) begin failures++; $display("FAIL rand_y cyc=%0d got=%h exp=%h", c, bus.o_y, m_y); end
        checks++; if (bus.o_y_last !== m_last) begin failures++; $display("FAIL rand_last cyc=%0d got=%b exp=%b", c, bus.o_y_last, m_last); end
      end
      checks++; if (bus.o_x_ready !== m_rdy()) begin failures++; $display("FAIL rand_xready cyc=%0d got=%b exp=%b", c, bus.o_x_ready, m_rdy()); end
      checks++; if (lfl !== 5'(m_lfq.size()) || hfl !== 5'(m_hfq.size())) begin failures++; $display("FAIL rand_levels cyc=%0d got=%0d/%0d exp=%0d/%0d", c, lfl, hfl, m_lfq.size(), m_hfq.size()); end
      checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", c, ovf, m_ovf); end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_real_mask();
    test_complex_mask();
    test_lf_only();
    test_back_to_back();
    test_overflow();
    test_frame_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
